// File: rtl/flick_pkg.sv
// flick_pkg: one-hot states, parameter defaults and widths shared by the flick debouncer.
package flick_pkg;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int MIN_HIGH_DEF        = 16;
    localparam int PRESS_CNT_W         = 8;
    typedef enum logic [3:0] {
        ST_IDLE         = 4'b0001,
        ST_PRESS_WAIT   = 4'b0010,
        ST_PRESSED      = 4'b0100,
        ST_RELEASE_WAIT = 4'b1000
    } state_t;
endpackage

// File: rtl/flick_sync.sv
// flick_sync: N-stage single-bit synchroniser, asynchronously cleared to 0.
module flick_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[N-2:0], i_d};
    end
    assign o_q = r_sync[N-1];
endmodule

// File: rtl/flick_debouncer.sv
// flick_debouncer: synchronises, debounces and stretches the flick button into a clean level
// with registered press/release pulses and an accepted-press counter.
module flick_debouncer
    import flick_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int MIN_HIGH        = MIN_HIGH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_raw,
    output logic                   flick,
    output logic                   flick_rise,
    output logic                   flick_fall,
    output logic [PRESS_CNT_W-1:0] press_cnt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(MIN_HIGH) + 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_HIGH - 1);

    state_t                 r_state;
    logic [DW-1:0]          r_deb_cnt;
    logic [HW-1:0]          r_hold_cnt;
    logic                   r_rise;
    logic                   r_fall;
    logic [PRESS_CNT_W-1:0] r_press_cnt;
    logic                   w_sync;

    flick_sync #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (btn_raw),
        .o_q   (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_sync) begin
                    r_state   <= ST_PRESS_WAIT;
                    r_deb_cnt <= '0;
                end
                ST_PRESS_WAIT: if (!w_sync) r_state <= ST_IDLE;
                else if (r_deb_cnt == DEB_LAST) begin
                    r_state     <= ST_PRESSED;
                    r_hold_cnt  <= HOLD_INIT;
                    r_rise      <= 1'b1;
                    r_press_cnt <= r_press_cnt + 1'b1;
                end else r_deb_cnt <= r_deb_cnt + 1'b1;
                ST_PRESSED: begin
                    if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
                    if (r_hold_cnt == '0 && !w_sync) begin
                        r_state   <= ST_RELEASE_WAIT;
                        r_deb_cnt <= '0;
                    end
                end
                // a bounce back high resumes the press with the hold already spent
                ST_RELEASE_WAIT: if (w_sync) r_state <= ST_PRESSED;
                else if (r_deb_cnt == DEB_LAST) begin
                    r_state <= ST_IDLE;
                    r_fall  <= 1'b1;
                end else r_deb_cnt <= r_deb_cnt + 1'b1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign flick      = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
    assign flick_rise = r_rise;
    assign flick_fall = r_fall;
    assign press_cnt  = r_press_cnt;
endmodule
